// File: rtl/cond_unit.sv
// cond_unit: ARM-style condition evaluation, architectural flag register {N,Z,C,V} and the E->M gated control register.
// Optional feature macro COND_UNIT_NV_TRAP_EN: adds UndefE and makes CondE = 4'b1111 fail instead of behaving as AL.
module cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic       PCSrcE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  input  logic       StallE,
  input  logic       FlushM,
  output logic [3:0] Flags,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic       PCSrcM,
  output logic       RegWriteM,
`ifdef COND_UNIT_NV_TRAP_EN
  output logic       UndefE,
`endif
  output logic       MemWriteM
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [3:0] r_flags;
  logic       r_pcsrc_m;
  logic       r_regwrite_m;
  logic       r_memwrite_m;
  logic       w_cond_pass;
  logic       w_nv;
  logic       w_cond_ex;

  // NV evaluates as AL here; the optional trap masks it afterwards.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n;
    logic z;
    logic c;
    logic v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond_e'(cond))
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Condition check against the registered flags only; no ALUFlags bypass.
  always_comb begin
    w_cond_pass = cond_pass(CondE, r_flags);
    w_nv        = (CondE == 4'b1111);
`ifdef COND_UNIT_NV_TRAP_EN
    w_cond_ex   = w_cond_pass & ~w_nv;
`else
    w_cond_ex   = w_cond_pass;
`endif
  end

`ifdef COND_UNIT_NV_TRAP_EN
  assign UndefE = w_nv;
`endif

  assign CondExE      = w_cond_ex;
  assign BranchTakenE = BranchE & w_cond_ex;
  assign Flags        = r_flags;

  // Flag register: NZ and CV halves are written independently; FlushM has no effect here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= FLAG_RESET;
    end else if (!StallE && w_cond_ex) begin
      if (FlagWriteE[1]) begin
        r_flags[3:2] <= ALUFlags[3:2];
      end
      if (FlagWriteE[0]) begin
        r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // M-stage register: flush beats stall so a bubble is inserted even while E is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (FlushM) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (!StallE) begin
      r_pcsrc_m    <= PCSrcE & w_cond_ex;
      r_regwrite_m <= RegWriteE & w_cond_ex;
      r_memwrite_m <= MemWriteE & w_cond_ex;
    end
  end

  assign PCSrcM    = r_pcsrc_m;
  assign RegWriteM = r_regwrite_m;
  assign MemWriteM = r_memwrite_m;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed vectors push expectations, monitors compare at negedge (comb) and after posedge (registered).
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] ALUFlags;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic       PCSrcE, RegWriteE, MemWriteE, BranchE, StallE, FlushM;
  logic [3:0] Flags;
  logic       CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM;
`ifdef COND_UNIT_NV_TRAP_EN
  logic       UndefE;
  localparam logic NV_PASS = 1'b0;
`else
  localparam logic NV_PASS = 1'b1;
`endif

  cond_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .ALUFlags(ALUFlags), .CondE(CondE), .FlagWriteE(FlagWriteE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .StallE(StallE), .FlushM(FlushM), .Flags(Flags), .CondExE(CondExE),
    .BranchTakenE(BranchTakenE), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
`ifdef COND_UNIT_NV_TRAP_EN
    .UndefE(UndefE),
`endif
    .MemWriteM(MemWriteM)
  );

  typedef struct {
    int    due;
    logic  condex;
    logic  bt;
    logic  undef;
    string name;
  } comb_exp_t;

  typedef struct {
    int         due;
    logic [3:0] flags;
    logic       pcs;
    logic       rw;
    logic       mw;
    string      name;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Combinational monitor: same cycle as the stimulus.
  initial begin
    comb_exp_t e;
    forever begin
      @(negedge clk);
      while (comb_q.size() > 0 && comb_q[0].due == cyc) begin
        e = comb_q.pop_front();
        chk({e.name, ".CondExE"}, {3'b000, CondExE}, {3'b000, e.condex});
        chk({e.name, ".BranchTakenE"}, {3'b000, BranchTakenE}, {3'b000, e.bt});
`ifdef COND_UNIT_NV_TRAP_EN
        chk({e.name, ".UndefE"}, {3'b000, UndefE}, {3'b000, e.undef});
`endif
      end
    end
  end

  // Registered monitor: state after the edge that consumed the stimulus.
  initial begin
    reg_exp_t r;
    forever begin
      @(posedge clk);
      #3;
      while (reg_q.size() > 0 && reg_q[0].due == cyc) begin
        r = reg_q.pop_front();
        chk({r.name, ".Flags"}, Flags, r.flags);
        chk({r.name, ".PCSrcM"}, {3'b000, PCSrcM}, {3'b000, r.pcs});
        chk({r.name, ".RegWriteM"}, {3'b000, RegWriteM}, {3'b000, r.rw});
        chk({r.name, ".MemWriteM"}, {3'b000, MemWriteM}, {3'b000, r.mw});
      end
    end
  end

  task automatic step(
    input string      nm,
    input logic       rst, input logic stl, input logic fl,
    input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
    input logic       pcs, input logic rw, input logic mw, input logic br,
    input bit         chk_comb, input logic ecx, input logic ebt,
    input logic [3:0] ef, input logic epc, input logic erw, input logic emw
  );
    comb_exp_t c;
    reg_exp_t  r;
    @(posedge clk);
    #1;
    reset = rst; StallE = stl; FlushM = fl; CondE = cond; FlagWriteE = fw; ALUFlags = alu;
    PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw; BranchE = br;
    if (chk_comb) begin
      c.due = cyc; c.condex = ecx; c.bt = ebt; c.undef = (cond == 4'b1111); c.name = nm;
      comb_q.push_back(c);
    end
    r.due = cyc + 1; r.flags = ef; r.pcs = epc; r.rw = erw; r.mw = emw; r.name = nm;
    reg_q.push_back(r);
  endtask

  initial begin
    reset = 1'b0; StallE = 1'b0; FlushM = 1'b0; CondE = 4'b0000; FlagWriteE = 2'b00;
    ALUFlags = 4'b0000; PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0;

    //    name          rst   stl   fl    cond     fw     alu      pcs   rw    mw    br    cc  cx    bt    flags    pcm   rwm   mwm
    step("reset",       1'b1, 1'b0, 1'b0, 4'b0000, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("eq_fail",     1'b0, 1'b0, 1'b0, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("al_write",    1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
    step("eq_pass",     1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
    step("set_1010",    1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
    step("nz_only",     1'b0, 1'b0, 1'b0, 4'b1110, 2'b10, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    step("cv_only",     1'b0, 1'b0, 1'b0, 4'b1110, 2'b01, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
    step("clr_flags",   1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("ne_stall",    1'b0, 1'b1, 1'b0, 4'b0001, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("ne_release",  1'b0, 1'b0, 1'b0, 4'b0001, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);
    step("ne_fail",     1'b0, 1'b0, 1'b0, 4'b0001, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("ge_pass",     1'b0, 1'b0, 1'b0, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
    step("stall_flush", 1'b0, 1'b1, 1'b1, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("flush_only",  1'b0, 1'b0, 1'b1, 4'b1110, 2'b11, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("nv",          1'b0, 1'b0, 1'b0, 4'b1111, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1, NV_PASS, NV_PASS,
         NV_PASS ? 4'b1000 : 4'b0010, 1'b0, NV_PASS, 1'b0);
    // Restore flags to 0010 (N0 Z0 C1 V0) for the condition sweep.
    step("set_0010",    1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("hi",          1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("ls",          1'b0, 1'b0, 1'b0, 4'b1001, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("lt",          1'b0, 1'b0, 1'b0, 4'b1011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("gt",          1'b0, 1'b0, 1'b0, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("le",          1'b0, 1'b0, 1'b0, 4'b1101, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("cs",          1'b0, 1'b0, 1'b0, 4'b0010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("cc",          1'b0, 1'b0, 1'b0, 4'b0011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("mi",          1'b0, 1'b0, 1'b0, 4'b0100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("pl",          1'b0, 1'b0, 1'b0, 4'b0101, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("vs",          1'b0, 1'b0, 1'b0, 4'b0110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("vc",          1'b0, 1'b0, 1'b0, 4'b0111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    step("ne_pass",     1'b0, 1'b0, 1'b0, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0);
    step("mid_reset",   1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("eq_after_rst",1'b0, 1'b0, 1'b0, 4'b0000, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    reset = 1'b0; StallE = 1'b0; FlushM = 1'b0; FlagWriteE = 2'b00;
    PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0;
    @(posedge clk);
    #6;
    n_cmp++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d comb and %0d reg expectations left, expected 0", comb_q.size(), reg_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
